mul_issue_pipe: RTL and testbench

- Two-stage pipelined control wrapper around the combinational Wallace multiplier in the EXE stage.
- Accepts mul.w / mulh.w / mulh.wu requests from EXE through a valid/ready handshake.
- Stage 1 registers the operands and drives them to the multiplier. Stage 2 captures the 64-bit product and selects the low or high word.
- Delivers a 32-bit result plus destination tag toward MEM/WB with full backpressure and flush support.

---
 rtl/mul_issue_pipe.sv | 130 +++++++++++++
 tb/tb_mul_issue_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_pipe.sv
// Two-stage control wrapper around the external combinational multiplier: stage 1 holds
// the operands that drive the multiplier, stage 2 holds the selected 32-bit result word.
module mul_issue_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_signed,
    input  logic [63:0]      mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready is a function of downstream state only and never looks at valid.
    logic             s2_ready;
    logic             accept;
    logic             move;
    logic [31:0]      sel_word;

    logic             v1_q, v1_d;
    logic [31:0]      a1_q, a1_d;
    logic [31:0]      b1_q, b1_d;
    logic [2:0]       op1_q, op1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    logic             v2_q, v2_d;
    logic [31:0]      res2_q, res2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    always_comb begin
        s2_ready = !v2_q || out_ready;
        in_ready = !v1_q || s2_ready;
        accept   = in_valid && in_ready && !flush;
        move     = v1_q && s2_ready;
    end

    // mul.w takes the low word, which is the same for signed and unsigned products.
    always_comb begin
        sel_word = 32'd0;
        if (op1_q[0]) begin
            sel_word = mul_product[31:0];
        end else if (op1_q[1]) begin
            sel_word = mul_product[63:32];
        end else if (op1_q[2]) begin
            sel_word = mul_product[63:32];
        end
    end

    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        op1_d  = op1_q;
        tag1_d = tag1_q;
        if (accept) begin
            v1_d   = 1'b1;
            a1_d   = in_src1;
            b1_d   = in_src2;
            op1_d  = in_op;
            tag1_d = in_tag;
        end else if (move) begin
            v1_d = 1'b0;
        end
        if (flush) begin
            v1_d = 1'b0;
        end
    end

    always_comb begin
        v2_d   = v2_q;
        res2_d = res2_q;
        tag2_d = tag2_q;
        if (move) begin
            v2_d   = 1'b1;
            res2_d = sel_word;
            tag2_d = tag1_q;
        end else if (v2_q && out_ready) begin
            v2_d = 1'b0;
        end
        if (flush) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            v1_q   <= 1'b0;
            a1_q   <= 32'd0;
            b1_q   <= 32'd0;
            op1_q  <= 3'd0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            res2_q <= 32'd0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            op1_q  <= op1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            res2_q <= res2_d;
            tag2_q <= tag2_d;
        end
    end

    always_comb begin
        mul_a      = a1_q;
        mul_b      = b1_q;
        mul_signed = op1_q[1];
        out_valid  = v2_q;
        out_result = res2_q;
        out_tag    = tag2_q;
        busy       = v1_q || v2_q;
    end

endmodule

// File: tb/tb_mul_issue_pipe.sv
// Bench for mul_issue_pipe: directed test-plan cases plus random traffic, scored against
// an occupancy/queue model of the pipeline and an arithmetic model of each op.
module tb_mul_issue_pipe;

    localparam int TAG_W = 5;
    localparam int EW    = TAG_W + 32;

    logic             mul_clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_signed;
    logic [63:0]      mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 mul_clk = ~mul_clk;

    // Stand-in for the combinational Wallace multiplier.
    logic [63:0] ext_a, ext_b;
    always_comb begin
        ext_a = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        ext_b = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        mul_product = ext_a * ext_b;
    end

    mul_issue_pipe #(.TAG_W(TAG_W)) dut (
        .mul_clk     (mul_clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_tag      (in_tag),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_signed  (mul_signed),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] s1,
                                               input logic [31:0] s2);
        longint      sp;
        logic [63:0] up;
        sp = longint'($signed(s1)) * longint'($signed(s2));
        up = {32'd0, s1} * {32'd0, s2};
        if (op[0]) return up[31:0];
        if (op[1]) return sp[63:32];
        if (op[2]) return up[63:32];
        return 32'd0;
    endfunction

    // Scoreboard: requests in flight in order, with the cycle each was accepted.
    logic [EW-1:0] exp_q[$];
    longint        acc_q[$];
    longint        cyc = 0;
    longint        last_retire = -10;
    bit            after_reset = 1'b0;
    logic          m_ready;
    logic          m_valid;

    always @(posedge mul_clk) cyc <= cyc + 1;

    always @(negedge mul_clk) begin
        if (!resetn) begin
            exp_q.delete();
            acc_q.delete();
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                check_eq("rst_out_result", 64'(out_result), 64'd0);
                check_eq("rst_out_tag", 64'(out_tag), 64'd0);
                check_eq("rst_mul_a", 64'(mul_a), 64'd0);
                check_eq("rst_mul_b", 64'(mul_b), 64'd0);
                check_eq("rst_mul_signed", 64'(mul_signed), 64'd0);
                after_reset = 1'b0;
            end
            m_ready = (exp_q.size() < 2) || out_ready;
            m_valid = 1'b0;
            if (exp_q.size() > 0) begin
                m_valid = (cyc >= acc_q[0] + 2) && (cyc >= last_retire + 1);
            end
            check_eq("in_ready", 64'(in_ready), 64'(m_ready));
            check_eq("out_valid", 64'(out_valid), 64'(m_valid));
            check_eq("busy", 64'(busy), 64'(exp_q.size() > 0));
            if (m_valid) begin
                check_eq("out_result", 64'(out_result), 64'(exp_q[0][31:0]));
                check_eq("out_tag", 64'(out_tag), 64'(exp_q[0][EW-1:32]));
            end
            if (flush) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (m_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    last_retire = cyc;
                end
                if (in_valid && m_ready) begin
                    exp_q.push_back({in_tag, ref_result(in_op, in_src1, in_src2)});
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic step_acc(output bit acc);
        #2;
        acc = in_valid && in_ready && resetn && !flush;
        @(posedge mul_clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_op    = op;
        in_src1  = s1;
        in_src2  = s2;
        in_tag   = tag;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_one(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp_res);
        set_req(1'b1, op, s1, s2, tag);
        step();
        in_valid = 1'b0;
        check_eq("lat_early", 64'(out_valid), 64'd0);
        step();
        check_eq("lat_valid", 64'(out_valid), 64'd1);
        check_eq("lat_result", 64'(out_result), 64'(exp_res));
        check_eq("lat_tag", 64'(out_tag), 64'(tag));
        step();
    endtask

    function automatic logic [31:0] pick_src();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_op [7] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [31:0] d_s1 [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] d_s2 [7] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_exp[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000,
                              32'h4000_0000, 32'h0000_0000, 32'hC000_0000};

    initial begin
        bit acc;
        int idx;
        int r;

        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_req(1'b0, 3'b000, 32'd0, 32'd0, '0);
        step();
        step();
        resetn = 1'b1;
        check_eq("por_in_ready", 64'(in_ready), 64'd1);
        check_eq("por_out_valid", 64'(out_valid), 64'd0);
        check_eq("por_busy", 64'(busy), 64'd0);
        idle(2);

        // Ops, extremes and latency.
        for (int i = 0; i < 7; i++) begin
            send_one(d_op[i], d_s1[i], d_s2[i], TAG_W'(i + 1), d_exp[i]);
        end
        idle(2);

        // Back-to-back throughput.
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                check_eq("tp_valid", 64'(out_valid), 64'd1);
                check_eq("tp_tag", 64'(out_tag), 64'(i - 1));
            end
            if (i < 8) begin
                check_eq("tp_in_ready", 64'(in_ready), 64'd1);
                set_req(1'b1, 3'b001, 32'(i), 32'd7, TAG_W'(i + 1));
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        idle(2);

        // Backpressure: three requests offered against a stalled consumer.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(1'b1, 3'b001, 32'(3 + idx), 32'd5, TAG_W'(10 + idx));
            step_acc(acc);
            if (acc) idx++;
            if (c >= 1) begin
                check_eq("bp_valid", 64'(out_valid), 64'd1);
                check_eq("bp_hold_result", 64'(out_result), 64'd15);
                check_eq("bp_hold_tag", 64'(out_tag), 64'd10);
            end
        end
        check_eq("bp_accepts", 64'(idx), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4 && idx < 3; c++) begin
            set_req(1'b1, 3'b001, 32'(3 + idx), 32'd5, TAG_W'(10 + idx));
            step_acc(acc);
            if (acc) idx++;
        end
        check_eq("bp_third_accepted", 64'(idx), 64'd3);
        idle(5);

        // Flush with both stages full and a request on the input.
        out_ready = 1'b0;
        set_req(1'b1, 3'b100, 32'd9, 32'd9, TAG_W'(20));
        step();
        set_req(1'b1, 3'b100, 32'd8, 32'd8, TAG_W'(21));
        step();
        check_eq("fl_full_busy", 64'(busy), 64'd1);
        set_req(1'b1, 3'b001, 32'd6, 32'd6, TAG_W'(30));
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_out_valid", 64'(out_valid), 64'd0);
        check_eq("fl_busy", 64'(busy), 64'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("fl_no_ghost", 64'(out_valid), 64'd0);
        end
        idle(2);

        // Reset with both stages full.
        out_ready = 1'b0;
        set_req(1'b1, 3'b010, 32'hDEAD_BEEF, 32'h1234_5678, TAG_W'(25));
        step();
        set_req(1'b1, 3'b001, 32'hCAFE_F00D, 32'h0000_0003, TAG_W'(26));
        step();
        in_valid = 1'b0;
        resetn   = 1'b0;
        step();
        resetn = 1'b1;
        check_eq("mr_out_valid", 64'(out_valid), 64'd0);
        check_eq("mr_out_result", 64'(out_result), 64'd0);
        check_eq("mr_out_tag", 64'(out_tag), 64'd0);
        check_eq("mr_mul_a", 64'(mul_a), 64'd0);
        check_eq("mr_busy", 64'(busy), 64'd0);
        check_eq("mr_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("mr_no_ghost", 64'(out_valid), 64'd0);
        end

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            r         = $urandom_range(0, 199);
            resetn    = (r != 0);
            flush     = (r >= 1 && r <= 4);
            set_req($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick_src(), pick_src(),
                    TAG_W'($urandom));
            out_ready = $urandom_range(0, 9) < 6;
            step();
        end
        resetn = 1'b1;
        idle(6);
        check_eq("end_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
